// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift unit: operation codes and FSM states.
package shift_sequencer_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// Combinational shift stage: moves d by one or two bit positions, left or right,
// with zero or sign fill on right shifts.
module shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d,
    input  logic             two,
    input  logic             right,
    input  logic             arith,
    output logic [WIDTH-1:0] q
);

    logic w_fill;

    always_comb begin
        // The sign bit of the current value feeds both vacated positions on a 2-bit arithmetic step.
        w_fill = arith & d[WIDTH-1];
        if (!right) begin
            q = two ? {d[WIDTH-3:0], 2'b00} : {d[WIDTH-2:0], 1'b0};
        end else begin
            q = two ? {w_fill, w_fill, d[WIDTH-1:2]} : {w_fill, d[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative SLL/SRL/SRA unit: one reusable 1-or-2-bit stage stepped by a small
// IDLE/SHIFT/DONE FSM with a start/busy/done handshake.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SAW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [SAW-1:0]   sa,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    // Handshake: start is sampled at a posedge only while busy is low (IDLE or DONE);
    // done is high for the single cycle in which out holds the finished result.

    state_t           r_state;
    state_t           w_state_next;
    logic [SAW-1:0]   r_rem;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_out;

    logic             w_accept;
    logic             w_two;
    logic [SAW-1:0]   w_rem_next;
    logic [WIDTH-1:0] w_step_q;

    assign w_accept   = start && (r_state != S_SHIFT);
    assign w_two      = (r_rem >= SAW'(2));
    assign w_rem_next = r_rem - (w_two ? SAW'(2) : SAW'(1));

    // Reserved op 2'b10 has op[0]==0, so it naturally executes as a left shift.
    shift_step #(.WIDTH(WIDTH)) u_step (
        .d     (r_out),
        .two   (w_two),
        .right (r_op[0]),
        .arith (r_op == OP_SRA),
        .q     (w_step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SHIFT: begin
                if (w_rem_next == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_next = (sa == '0) ? S_DONE : S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_SHIFT);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_rem <= '0;
            r_op  <= OP_SLL;
        end else if (w_accept) begin
            r_out <= in0;
            r_rem <= sa;
            r_op  <= op;
        end else if (r_state == S_SHIFT) begin
            r_out <= w_step_q;
            r_rem <= w_rem_next;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed handshake scenarios plus randomized
// operations compared against a plain-arithmetic shift model.
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] in0;
    logic [4:0]  sa;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int checks = 0;
    int passed = 0;

    shift_sequencer #(.WIDTH(32), .SAW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in0   (in0),
        .sa    (sa),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(input logic [1:0] m_op, input logic [31:0] m_in,
                                                 input int m_sa);
        case (m_op)
            2'b01:   return m_in >> m_sa;
            2'b11:   return 32'($signed(m_in) >>> m_sa);
            default: return m_in << m_sa;
        endcase
    endfunction

    function automatic int model_latency(input int m_sa);
        return (m_sa + 1) / 2 + 1;
    endfunction

    // Drives one accepted operation and observes it until done (bounded).
    task automatic do_op(input logic [1:0] t_op, input logic [31:0] t_in, input logic [4:0] t_sa,
                         output int lat, output bit busy_bad, output logic [31:0] res);
        int cycle;
        @(negedge clk);
        start = 1'b1;
        op    = t_op;
        in0   = t_in;
        sa    = t_sa;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in0      = $urandom;
        sa       = 5'($urandom);
        cycle    = 1;
        lat      = -1;
        busy_bad = 1'b0;
        res      = 'x;
        while (cycle <= 40) begin
            if (done === 1'b1) begin
                lat = cycle;
                res = out;
                if (busy !== 1'b0) busy_bad = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            cycle++;
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] t_op, input logic [31:0] t_in,
                            input logic [4:0] t_sa);
        int          lat;
        bit          busy_bad;
        logic [31:0] res;
        logic [31:0] exp_res;
        int          exp_lat;
        exp_res = model_result(t_op, t_in, int'(t_sa));
        exp_lat = model_latency(int'(t_sa));
        do_op(t_op, t_in, t_sa, lat, busy_bad, res);
        checks++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        else passed++;
        checks++;
        if (busy_bad) $display("FAIL %s busy: got irregular busy expected high until done cycle", name);
        else passed++;
        checks++;
        if (res !== exp_res) $display("FAIL %s out: got %08h expected %08h", name, res, exp_res);
        else passed++;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in0   = '0;
        sa    = '0;
        op    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0)
            $display("FAIL reset: got busy=%b done=%b out=%08h expected 0 0 00000000", busy, done, out);
        else passed++;
    endtask

    task automatic test_directed();
        check_op("sll_1_by_5",  2'b00, 32'h0000_0001, 5'd5);
        check_op("sra_neg_31",  2'b11, 32'h8000_0000, 5'd31);
        check_op("sra_pos_31",  2'b11, 32'h7FFF_FFFF, 5'd31);
        check_op("srl_31",      2'b01, 32'h8000_0000, 5'd31);
        check_op("reserved_op", 2'b10, 32'h0000_0001, 5'd4);
        check_op("sa_zero",     2'b01, 32'h1234_5678, 5'd0);
    endtask

    task automatic test_ignore_start();
        int          lat;
        bit          busy_bad;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1; op = 2'b00; in0 = 32'h1; sa = 5'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b1; in0 = 32'h0000_FFFF; sa = 5'd1; op = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL ignore_busy: got busy=%b expected 1", busy);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || out !== 32'h40)
            $display("FAIL ignore_result: got done=%b out=%08h expected 1 00000040", done, out);
        else passed++;
        // Start issued in the DONE cycle must be taken with no idle gap.
        do_op(2'b01, 32'h100, 5'd8, lat, busy_bad, res);
        checks++;
        if (lat !== 5 || res !== 32'h1)
            $display("FAIL back_to_back: got lat=%0d out=%08h expected 5 00000001", lat, res);
        else passed++;
    endtask

    task automatic test_reset_midop();
        bit saw_done;
        @(negedge clk);
        start = 1'b1; op = 2'b01; in0 = 32'hF000_0000; sa = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0)
            $display("FAIL midop_reset: got busy=%b done=%b out=%08h expected 0 0 00000000", busy, done, out);
        else passed++;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) $display("FAIL midop_abandon: got activity after reset expected none");
        else passed++;
        check_op("after_reset", 2'b01, 32'h100, 5'd8);
    endtask

    task automatic test_random();
        logic [1:0]  r_op;
        logic [31:0] r_in;
        logic [4:0]  r_sa;
        logic [31:0] hold;
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_in = $urandom;
            r_sa = 5'($urandom_range(0, 31));
            check_op($sformatf("rand%0d", i), r_op, r_in, r_sa);
            if ($urandom_range(0, 2) == 0) begin
                hold = model_result(r_op, r_in, int'(r_sa));
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                checks++;
                if (out !== hold || done !== 1'b0 || busy !== 1'b0)
                    $display("FAIL idle_hold%0d: got out=%08h done=%b busy=%b expected %08h 0 0",
                             i, out, done, busy, hold);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_midop();
        test_random();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
